// File: rtl/led_pattern_rotator.sv
// LED pattern sequencer: a prescaled tick steps a WIDTH-bit pattern by rotating
// it left or right, bouncing it between the ends, or holding it. A parallel load is also supported.
module led_pattern_rotator #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     d,
  output logic                 step
);

  localparam logic [WIDTH-1:0]     D_INIT  = 1;
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    MODE_ROT_LEFT  = 2'b00,
    MODE_ROT_RIGHT = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  logic [DIV_WIDTH-1:0] cnt;
  logic                 dir_left;
  logic [WIDTH-1:0]     d_next;
  logic                 dir_left_next;
  logic                 tick;

  assign tick = en && (cnt == div);

  always_comb begin
    d_next        = d;
    dir_left_next = dir_left;
    case (mode_e'(mode))
      MODE_ROT_LEFT: begin
        d_next        = {d[WIDTH-2:0], d[WIDTH-1]};
        dir_left_next = 1'b1;
      end
      MODE_ROT_RIGHT: begin
        d_next        = {d[0], d[WIDTH-1:1]};
        dir_left_next = 1'b0;
      end
      MODE_BOUNCE: begin
        // Both end bits lit: nowhere to go, so the pattern parks.
        if (d[WIDTH-1] && d[0]) begin
          d_next = d;
        end else if (dir_left) begin
          if (d[WIDTH-1]) begin
            d_next        = d >> 1;
            dir_left_next = 1'b0;
          end else begin
            d_next = d << 1;
          end
        end else begin
          if (d[0]) begin
            d_next        = d << 1;
            dir_left_next = 1'b1;
          end else begin
            d_next = d >> 1;
          end
        end
      end
      default: begin
        d_next        = d;
        dir_left_next = dir_left;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d        <= D_INIT;
      dir_left <= 1'b1;
      cnt      <= '0;
      step     <= 1'b0;
    end else if (load) begin
      // A load restarts the step period and swallows a coincident tick.
      d    <= load_val;
      cnt  <= '0;
      step <= 1'b0;
    end else if (tick) begin
      d        <= d_next;
      dir_left <= dir_left_next;
      cnt      <= '0;
      step     <= 1'b1;
    end else begin
      if (en) begin
        cnt <= cnt + CNT_ONE;
      end
      step <= 1'b0;
    end
  end

endmodule
